mult_share_arbiter: RTL

- Shares one qlal4s3_mult_cell_macro hard multiplier between NREQ requesters.
- Each requester issues either a narrow 16x16 job or a wide 32x32 job.
- Per cycle the block grants either one wide job (macro in 32x32 mode) or up to two narrow jobs (lane 1 and lane 2 of the dual 16x16 mode).
- It registers the operands into the macro, captures the product and routes it back to the owner with a fixed 2-cycle latency.

---
 rtl/mult_share_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Shares one dual-mode hard multiplier between NREQ requesters: one 32x32 job
// or up to two paired 16x16 jobs per cycle, results returned 2 cycles after handshake.
module mult_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [64*NREQ-1:0]   rsp_data,
  output logic [31:0]          mult_a,
  output logic [31:0]          mult_b,
  output logic [1:0]           mult_valid,
  output logic                 mult_sel32,
  input  logic [63:0]          mult_c
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic [63:0]     rsp_data_reg [NREQ];
  logic [NREQ-1:0] rsp_valid_reg;
  logic [NREQ-1:0] hit_f;
  logic [NREQ-1:0] hit_n;

  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0] grant;
  logic            f_found, f_wide, n_found;
  logic [PW-1:0]   f_idx, n_idx;

  logic [31:0]     mult_a_reg, mult_b_reg;
  logic [1:0]      mult_valid_reg;
  logic            mult_sel32_reg;
  logic [PW-1:0]   own_f_reg, own_n_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
      assign rsp_data[64*gi +: 64] = rsp_data_reg[gi];
      // Which requester owns each lane of the product coming back this cycle.
      assign hit_f[gi] = mult_valid_reg[0] && (own_f_reg == PW'(gi));
      assign hit_n[gi] = mult_valid_reg[1] && !mult_sel32_reg && (own_n_reg == PW'(gi));
    end
  endgenerate

  // Round-robin scan from ptr: first valid wins; a narrow winner pulls in the
  // next narrow requester, skipping any wide ones in between.
  always_comb begin : arb
    int            s;
    logic [PW-1:0] idx;
    logic [PW-1:0] last;
    s        = 0;
    idx      = '0;
    last     = '0;
    grant    = '0;
    f_found  = 1'b0;
    f_wide   = 1'b0;
    n_found  = 1'b0;
    f_idx    = '0;
    n_idx    = '0;
    ptr_next = ptr_reg;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr_reg) + k;
      if (s >= NREQ) s = s - NREQ;
      idx = PW'(s);
      if (req_valid[idx]) begin
        if (!f_found) begin
          f_found = 1'b1;
          f_idx   = idx;
          f_wide  = req_wide[idx];
        end else if (!f_wide && !n_found && !req_wide[idx]) begin
          n_found = 1'b1;
          n_idx   = idx;
        end
      end
    end
    if (cfg_enable && !reset && f_found) begin
      grant[f_idx] = 1'b1;
      if (n_found) grant[n_idx] = 1'b1;
      last     = n_found ? n_idx : f_idx;
      ptr_next = (last == PW'(NREQ - 1)) ? '0 : last + 1'b1;
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= '0;
      mult_a_reg     <= '0;
      mult_b_reg     <= '0;
      mult_valid_reg <= '0;
      mult_sel32_reg <= 1'b0;
      own_f_reg      <= '0;
      own_n_reg      <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      own_f_reg <= f_idx;
      own_n_reg <= n_idx;
      if (|grant) begin
        if (f_wide) begin
          mult_a_reg     <= a_arr[f_idx];
          mult_b_reg     <= b_arr[f_idx];
          mult_valid_reg <= 2'b11;
          mult_sel32_reg <= 1'b1;
        end else begin
          mult_a_reg     <= {n_found ? a_arr[n_idx][15:0] : 16'h0, a_arr[f_idx][15:0]};
          mult_b_reg     <= {n_found ? b_arr[n_idx][15:0] : 16'h0, b_arr[f_idx][15:0]};
          mult_valid_reg <= {n_found, 1'b1};
          mult_sel32_reg <= 1'b0;
        end
      end else begin
        mult_a_reg     <= '0;
        mult_b_reg     <= '0;
        mult_valid_reg <= '0;
        mult_sel32_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= '0;
      for (int i = 0; i < NREQ; i++) rsp_data_reg[i] <= '0;
    end else begin
      rsp_valid_reg <= hit_f | hit_n;
      for (int i = 0; i < NREQ; i++) begin
        if (hit_f[i])
          rsp_data_reg[i] <= mult_sel32_reg ? mult_c : {32'h0, mult_c[31:0]};
        else if (hit_n[i])
          rsp_data_reg[i] <= {32'h0, mult_c[63:32]};
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign mult_a     = mult_a_reg;
  assign mult_b     = mult_b_reg;
  assign mult_valid = mult_valid_reg;
  assign mult_sel32 = mult_sel32_reg;

endmodule
